// File: rtl/trace_arbiter.sv
// trace_arbiter: shares one cache-simulator core among NUM_REQ trace
// requesters. Grants are round-robin. The arbiter drives the core's
// trace_ready/mem_addr handshake, waits for the core's updated pulse, and
// then acknowledges the granted requester. All outputs are registered.
// Optional WAIT watchdog: compile with TRACE_TIMEOUT_EN defined.
module trace_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned CNT_W          = 20,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic                        trace_ready,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic                        updated,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic [CNT_W-1:0]            issue_count,
    output logic                        timeout_err
);

    localparam int unsigned ID_W   = $clog2(NUM_REQ);
    localparam int unsigned SCAN_W = ID_W + 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("trace_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [NUM_REQ-1:0]  r_req_ack;
    logic                r_trace_ready;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [ID_W-1:0]     r_grant_id;
    logic                r_busy;
    logic [CNT_W-1:0]    r_issue_count;
    logic [ID_W-1:0]     r_rr_ptr;

    logic [NUM_REQ-1:0]  w_req_ack_nxt;
    logic                w_trace_ready_nxt;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic [ID_W-1:0]     w_grant_id_nxt;
    logic                w_busy_nxt;
    logic [CNT_W-1:0]    w_issue_count_nxt;
    logic [ID_W-1:0]     w_rr_ptr_nxt;

    logic [NUM_REQ-1:0]  w_eligible;
    logic [SCAN_W-1:0]   w_scan;
    logic                w_win_found;
    logic [ID_W-1:0]     w_win_idx;
    logic                w_done;
    logic                w_tmo_hit;

    // The just-acknowledged requester is masked out for one cycle so its stale address is never re-granted.
    assign w_eligible = req_valid & ~r_req_ack;

    // Round-robin search: first eligible index starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_scan      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_scan = {1'b0, r_rr_ptr} + SCAN_W'(i);
            if (w_scan >= SCAN_W'(NUM_REQ)) begin
                w_scan = w_scan - SCAN_W'(NUM_REQ);
            end
            if (!w_win_found && w_eligible[w_scan[ID_W-1:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_scan[ID_W-1:0];
            end
        end
    end

`ifdef TRACE_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TO_W-1:0] r_wait_cnt;
    logic            r_timeout_err;

    // Watchdog fires in the WAIT cycle where the count reaches the limit.
    // A coincident updated takes precedence as a normal completion.
    assign w_tmo_hit = (r_state == S_WAIT) && !updated &&
                       (r_wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Wait counter: held at zero outside WAIT, so every WAIT entry starts from zero.
    always_ff @(posedge clk) begin
        if (rst || r_state != S_WAIT) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout_err <= 1'b0;
        end else if (w_tmo_hit) begin
            r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_tmo_hit   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign w_done = (r_state == S_WAIT) && (updated || w_tmo_hit);

    // Next-state and next-output logic for the IDLE/ISSUE/WAIT handshake FSM.
    always_comb begin
        w_state_nxt       = r_state;
        w_req_ack_nxt     = '0;
        w_trace_ready_nxt = 1'b0;
        w_mem_addr_nxt    = r_mem_addr;
        w_grant_id_nxt    = r_grant_id;
        w_busy_nxt        = r_busy;
        w_issue_count_nxt = r_issue_count;
        w_rr_ptr_nxt      = r_rr_ptr;
        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (w_win_found) begin
                    w_state_nxt       = S_ISSUE;
                    w_trace_ready_nxt = 1'b1;
                    w_busy_nxt        = 1'b1;
                    w_mem_addr_nxt    = req_addr[w_win_idx*ADDR_W +: ADDR_W];
                    w_grant_id_nxt    = w_win_idx;
                    if (r_issue_count != '1) begin
                        w_issue_count_nxt = r_issue_count + 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
                w_busy_nxt  = 1'b1;
            end
            S_WAIT: begin
                w_busy_nxt = 1'b1;
                if (w_done) begin
                    w_state_nxt   = S_IDLE;
                    w_busy_nxt    = 1'b0;
                    w_req_ack_nxt = NUM_REQ'(1) << r_grant_id;
                    w_rr_ptr_nxt  = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered outputs and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_ack     <= '0;
            r_trace_ready <= 1'b0;
            r_mem_addr    <= '0;
            r_grant_id    <= '0;
            r_busy        <= 1'b0;
            r_issue_count <= '0;
            r_rr_ptr      <= '0;
        end else begin
            r_req_ack     <= w_req_ack_nxt;
            r_trace_ready <= w_trace_ready_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_busy        <= w_busy_nxt;
            r_issue_count <= w_issue_count_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
        end
    end

    assign req_ack     = r_req_ack;
    assign trace_ready = r_trace_ready;
    assign mem_addr    = r_mem_addr;
    assign grant_id    = r_grant_id;
    assign busy        = r_busy;
    assign issue_count = r_issue_count;

endmodule
